// File: rtl/uart_tx_byte.sv
// 8N1/8N2 UART transmitter fed by the register-file dump engine.
// Tx_busy rises the cycle after an accepted strobe and paces the engine byte by byte.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       Ready_Byte,
    output logic       tx,
    output logic       Tx_busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CYCLE = 16'(CLKS_PER_BIT - 1);
    localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);

    state_t      state, state_n;
    logic [15:0] cycle_cnt, cycle_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        stop_idx, stop_idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n, busy_n, overrun_n;
    logic        bit_end, final_stop, accept;

    always_ff @(posedge clk_50M) begin
        if (!rst) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            tx        <= 1'b1;
            Tx_busy   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cycle_cnt <= cycle_cnt_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift     <= shift_n;
            tx        <= tx_n;
            Tx_busy   <= busy_n;
            overrun   <= overrun_n;
        end
    end

    // A strobe is only taken in IDLE or on the very last stop cycle; anything else while busy is dropped.
    always_comb begin
        state_n     = state;
        cycle_cnt_n = cycle_cnt;
        bit_idx_n   = bit_idx;
        stop_idx_n  = stop_idx;
        shift_n     = shift;
        tx_n        = tx;
        busy_n      = Tx_busy;
        overrun_n   = overrun;

        bit_end    = (cycle_cnt == LAST_CYCLE);
        final_stop = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
        accept     = Ready_Byte && ((state == IDLE) || final_stop);

        if (Ready_Byte && Tx_busy && !accept) begin
            overrun_n = 1'b1;
        end

        if (state != IDLE) begin
            cycle_cnt_n = bit_end ? 16'd0 : cycle_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    tx_n      = shift[0];
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        tx_n       = 1'b1;
                        stop_idx_n = 1'b0;
                        state_n    = STOP;
                    end else begin
                        tx_n      = shift[1];
                        shift_n   = {1'b0, shift[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == LAST_STOP) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Acceptance overrides the stop-bit exit so back-to-back frames have no idle gap.
        if (accept) begin
            shift_n     = data_in;
            tx_n        = 1'b0;
            busy_n      = 1'b1;
            cycle_cnt_n = 16'd0;
            state_n     = START;
        end
    end

endmodule
